// File: rtl/execute_cc_stage.sv
// ============================================================================
//  Module   : execute_cc_stage
//  Purpose  : Registered Y86-64 Execute stage: ALU, condition codes, Cnd and
//             a RUN/HALTED status controller.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module execute_cc_stage #(
    parameter int WIDTH      = 64,
    parameter int STACK_STEP = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             stall,
    input  logic [3:0]       icode,
    input  logic [3:0]       ifun,
    input  logic [WIDTH-1:0] valA,
    input  logic [WIDTH-1:0] valB,
    input  logic [WIDTH-1:0] valC,
    output logic             out_valid,
    output logic [WIDTH-1:0] valE,
    output logic             cnd,
    output logic [2:0]       cc,
    output logic             halted,
    output logic             instr_err
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] C_STEP = WIDTH'(STACK_STEP);

    state_t           r_state;
    state_t           w_state_next;
    logic             w_accept;
    logic             w_invalid;
    logic [WIDTH-1:0] w_val_e;
    logic             w_cnd;
    logic             w_of;
    logic [2:0]       w_cc_next;
    logic             w_cc_we;
    logic             w_zf;
    logic             w_sf;
    logic             w_ovf;

    assign w_accept = (r_state == ST_RUN) && in_valid && !stall;

    assign w_invalid = (icode > 4'hB)
                    || ((icode == 4'h6) && (ifun > 4'h3))
                    || (((icode == 4'h2) || (icode == 4'h7)) && (ifun > 4'h6));

    // Flags as they stand before this edge; jXX/cmov after an OPq see its result.
    assign w_zf  = cc[2];
    assign w_sf  = cc[1];
    assign w_ovf = cc[0];

    always_comb begin
        w_val_e = '0;
        w_of    = 1'b0;
        if (!w_invalid) begin
            case (icode)
                4'h2: w_val_e = valA;
                4'h3: w_val_e = valC;
                4'h4, 4'h5: w_val_e = valB + valC;
                4'h6: begin
                    case (ifun)
                        4'h0: begin
                            w_val_e = valB + valA;
                            w_of    = (valA[WIDTH-1] == valB[WIDTH-1])
                                   && (w_val_e[WIDTH-1] != valA[WIDTH-1]);
                        end
                        4'h1: begin
                            w_val_e = valB - valA;
                            w_of    = (valA[WIDTH-1] != valB[WIDTH-1])
                                   && (w_val_e[WIDTH-1] != valB[WIDTH-1]);
                        end
                        4'h2:    w_val_e = valB & valA;
                        4'h3:    w_val_e = valB ^ valA;
                        default: w_val_e = '0;
                    endcase
                end
                4'h8, 4'hA: w_val_e = valB - C_STEP;
                4'h9, 4'hB: w_val_e = valB + C_STEP;
                default:    w_val_e = '0;
            endcase
        end
    end

    always_comb begin
        w_cnd = 1'b0;
        if (!w_invalid && ((icode == 4'h2) || (icode == 4'h7))) begin
            case (ifun)
                4'h0:    w_cnd = 1'b1;
                4'h1:    w_cnd = (w_sf ^ w_ovf) | w_zf;
                4'h2:    w_cnd = w_sf ^ w_ovf;
                4'h3:    w_cnd = w_zf;
                4'h4:    w_cnd = !w_zf;
                4'h5:    w_cnd = !(w_sf ^ w_ovf);
                4'h6:    w_cnd = !(w_sf ^ w_ovf) && !w_zf;
                default: w_cnd = 1'b0;
            endcase
        end
    end

    assign w_cc_we   = w_accept && !w_invalid && (icode == 4'h6);
    assign w_cc_next = {(w_val_e == '0), w_val_e[WIDTH-1], w_of};

    always_comb begin
        w_state_next = r_state;
        if (w_accept && (w_invalid || (icode == 4'h0))) begin
            w_state_next = ST_HALTED;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            valE      <= '0;
            cnd       <= 1'b0;
            cc        <= 3'b100;
            instr_err <= 1'b0;
        end else if (!stall) begin
            if (w_accept) begin
                out_valid <= 1'b1;
                valE      <= w_val_e;
                cnd       <= w_cnd;
                if (w_cc_we) begin
                    cc <= w_cc_next;
                end
                if (w_invalid) begin
                    instr_err <= 1'b1;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    assign halted = (r_state == ST_HALTED);

endmodule

`default_nettype wire

// File: tb/tb_execute_cc_stage.sv
// ============================================================================
//  Module   : tb_execute_cc_stage
//  Purpose  : Directed and randomized checking of execute_cc_stage against a
//             behavioural instruction-level model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_execute_cc_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        stall;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] valC;
    logic        out_valid;
    logic [63:0] valE;
    logic        cnd;
    logic [2:0]  cc;
    logic        halted;
    logic        instr_err;

    int n_checks;
    int n_errors;

    // Reference model state
    logic        m_ov;
    logic [63:0] m_ve;
    logic        m_cnd;
    logic        m_zf, m_sf, m_of;
    logic        m_halted;
    logic        m_err;

    execute_cc_stage #(.WIDTH(64), .STACK_STEP(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .stall     (stall),
        .icode     (icode),
        .ifun      (ifun),
        .valA      (valA),
        .valB      (valB),
        .valC      (valC),
        .out_valid (out_valid),
        .valE      (valE),
        .cnd       (cnd),
        .cc        (cc),
        .halted    (halted),
        .instr_err (instr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic cond_holds(input logic [3:0] fn, input logic zf, sf, of);
        logic lt;
        lt = (sf != of);
        case (fn)
            4'd0:    return 1'b1;
            4'd1:    return lt || zf;
            4'd2:    return lt;
            4'd3:    return zf;
            4'd4:    return !zf;
            4'd5:    return !lt;
            4'd6:    return !lt && !zf;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_accept(input logic [3:0] ic, fn, input logic [63:0] a, b, c);
        logic signed [64:0] wide;
        logic [63:0] res;
        logic bad;
        bad = (ic > 11) || (ic == 6 && fn > 3) || ((ic == 2 || ic == 7) && fn > 6);
        m_ov  = 1'b1;
        m_ve  = 64'd0;
        m_cnd = 1'b0;
        if (bad) begin
            m_halted = 1'b1;
            m_err    = 1'b1;
        end else begin
            case (ic)
                0: m_halted = 1'b1;
                2: begin m_ve = a; m_cnd = cond_holds(fn, m_zf, m_sf, m_of); end
                3: m_ve = c;
                4, 5: m_ve = b + c;
                6: begin
                    // Overflow means the exact 65-bit signed result does not fit in 64 bits.
                    wide = '0;
                    case (fn)
                        0: begin wide = $signed({b[63], b}) + $signed({a[63], a}); res = wide[63:0]; end
                        1: begin wide = $signed({b[63], b}) - $signed({a[63], a}); res = wide[63:0]; end
                        2: res = b & a;
                        default: res = b ^ a;
                    endcase
                    m_ve = res;
                    m_zf = (res == 64'd0);
                    m_sf = res[63];
                    m_of = (fn <= 1) ? (wide[64] != wide[63]) : 1'b0;
                end
                7: m_cnd = cond_holds(fn, m_zf, m_sf, m_of);
                8, 10: m_ve = b - 64'd8;
                9, 11: m_ve = b + 64'd8;
                default: m_ve = 64'd0;
            endcase
        end
    endtask

    task automatic step(input logic r, s, v, input logic [3:0] ic, fn,
                        input logic [63:0] a, b, c);
        rst = r; stall = s; in_valid = v; icode = ic; ifun = fn;
        valA = a; valB = b; valC = c;
        @(posedge clk);
        if (r) begin
            m_ov = 0; m_ve = 0; m_cnd = 0;
            m_zf = 1; m_sf = 0; m_of = 0;
            m_halted = 0; m_err = 0;
        end else if (!s) begin
            if (!m_halted && v) model_accept(ic, fn, a, b, c);
            else                m_ov = 1'b0;
        end
        #1;
        check("out_valid", {63'd0, out_valid}, {63'd0, m_ov});
        check("valE", valE, m_ve);
        check("cnd", {63'd0, cnd}, {63'd0, m_cnd});
        check("cc", {61'd0, cc}, {61'd0, m_zf, m_sf, m_of});
        check("halted", {63'd0, halted}, {63'd0, m_halted});
        check("instr_err", {63'd0, instr_err}, {63'd0, m_err});
    endtask

    function automatic logic [63:0] rand64();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return 64'h7FFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return {56'd0, 8'($urandom)};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_ov = 0; m_ve = 0; m_cnd = 0; m_zf = 1; m_sf = 0; m_of = 0;
        m_halted = 0; m_err = 0;
        rst = 1; stall = 0; in_valid = 0; icode = 0; ifun = 0;
        valA = 0; valB = 0; valC = 0;
        @(negedge clk);

        step(1, 0, 0, 0, 0, 0, 0, 0);
        check("reset_cc", {61'd0, cc}, 64'd4);

        // add overflow into the sign bit
        step(0, 0, 1, 6, 0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0);
        check("add_valE", valE, 64'h8000_0000_0000_0000);
        check("add_cc", {61'd0, cc}, 64'd3);

        // sub equal then je
        step(0, 0, 1, 6, 1, 64'd5, 64'd5, 0);
        check("sub_cc", {61'd0, cc}, 64'd4);
        step(0, 0, 1, 7, 3, 64'd1, 64'd2, 64'd3);
        check("je_cnd", {63'd0, cnd}, 64'd1);

        // and then cmovl
        step(0, 0, 1, 6, 2, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        check("and_valE", valE, 64'hF0F0_F0F0_F0F0_F0F0);
        step(0, 0, 1, 2, 2, 64'd9, 64'd0, 0);
        check("cmovl_valE", valE, 64'd9);

        // push / pop
        step(0, 0, 1, 10, 0, 0, 64'h100, 0);
        check("push_valE", valE, 64'hF8);
        step(0, 0, 1, 11, 0, 0, 64'hF8, 0);
        check("pop_valE", valE, 64'h100);

        // stall holds for three cycles, then single acceptance
        for (int i = 0; i < 3; i++) step(0, 1, 1, 6, 1, 64'd3, 64'd1, 0);
        step(0, 0, 1, 6, 1, 64'd3, 64'd1, 0);
        check("stall_release_valE", valE, 64'hFFFF_FFFF_FFFF_FFFE);
        step(0, 0, 0, 6, 1, 64'd3, 64'd1, 0);

        // invalid icode, ignored input while halted, reset recovery
        step(0, 0, 1, 12, 0, 0, 0, 0);
        step(0, 0, 1, 6, 0, 64'd1, 64'd1, 0);
        check("halted_ignores", {63'd0, out_valid}, 64'd0);
        step(0, 1, 1, 6, 0, 64'd1, 64'd1, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        check("reset_halted", {63'd0, halted}, 64'd0);

        // halt instruction
        step(0, 0, 1, 0, 5, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic r, s, v;
            logic [3:0] ic, fn;
            logic [63:0] a, b;
            r  = ($urandom_range(0, 49) == 0) || (m_halted && $urandom_range(0, 3) == 0);
            s  = ($urandom_range(0, 4) == 0);
            v  = ($urandom_range(0, 5) != 0);
            ic = ($urandom_range(0, 19) == 0) ? 4'($urandom) :
                 ($urandom_range(0, 2) == 0) ? 4'd6 : 4'($urandom_range(1, 11));
            fn = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(0, 6));
            if (ic == 6 && $urandom_range(0, 9) != 0) fn = 4'($urandom_range(0, 3));
            a  = rand64();
            b  = ($urandom_range(0, 4) == 0) ? a : rand64();
            step(r, s, v, ic, fn, a, b, rand64());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
